// File: rtl/k2red_unit.sv
// Three-stage K-RED pipeline for the Kyber modulus: cred = (K^2 * c) mod Q.
// Two KRED folds bring a 24-bit operand into a narrow signed band; a final add/sub makes it canonical.
module k2red_unit #(
  parameter int Q = 3329,
  parameter int K = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [23:0] c,
  output logic        out_valid,
  output logic [11:0] cred
);

  localparam int STAGES = 3;
  localparam logic signed [12:0] QS = 13'(Q);

  // K*x for an 8-bit x; K*255 = 3315 fits in 12 bits.
  function automatic logic [11:0] mulk(input logic [7:0] x);
    return 12'(K) * {4'b0, x};
  endfunction

  logic [STAGES-1:0]  vld_pipe_q, vld_pipe_d;
  logic signed [17:0] c1_q, c1_d;
  logic signed [12:0] c2_q, c2_d;
  logic [11:0]        cred_q, cred_d;
  logic signed [12:0] c1_sh;
  logic signed [12:0] c2_fix;

  // Stage 1: fold the high 16 bits against K*low byte (2^8 == -1/K mod Q).
  assign c1_d = $signed({6'b0, mulk(c[7:0])}) - $signed({2'b0, c[23:8]});

  // Stage 2: same fold on the signed C1; the shifted part lies in -256..12.
  assign c1_sh = 13'(c1_q >>> 8);
  assign c2_d  = $signed({1'b0, mulk(c1_q[7:0])}) - c1_sh;

  // Stage 3: C2 spans -12..3571, so a single correction by Q is enough.
  always_comb begin
    c2_fix = c2_q;
    if (c2_q < 0)        c2_fix = c2_q + QS;
    else if (c2_q >= QS) c2_fix = c2_q - QS;
    cred_d = 12'(c2_fix);
  end

  assign vld_pipe_d = {vld_pipe_q[STAGES-2:0], in_valid};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      c1_q       <= '0;
      c2_q       <= '0;
      cred_q     <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      if (in_valid)      c1_q   <= c1_d;
      if (vld_pipe_q[0]) c2_q   <= c2_d;
      if (vld_pipe_q[1]) cred_q <= cred_d;
    end
  end

  assign out_valid = vld_pipe_q[STAGES-1];
  assign cred      = cred_q;

endmodule

// File: tb/tb_k2red_unit.sv
// Directed and randomized check of k2red_unit against (169*c) mod 3329 with 3-cycle latency.
module tb_k2red_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [23:0] c = '0;
  logic        out_valid;
  logic [11:0] cred;

  k2red_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .c(c),
    .out_valid(out_valid), .cred(cred)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [11:0] val;
  } exp_t;

  exp_t        expq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [11:0] last_cred = '0;

  function automatic logic [11:0] ref_red(input logic [23:0] x);
    longint prod;
    prod = 169 * longint'(x);
    return 12'(prod % 3329);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive inputs, take the edge, then compare 1 time unit later.
  task automatic tick(input logic v, input logic [23:0] x, input logic r);
    rst = r; in_valid = v; c = x;
    @(posedge clk);
    cyc++;
    if (r) expq.delete();
    else if (v) expq.push_back('{cyc + 2, ref_red(x)});
    #1;
    if (r) begin
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_cred", {20'b0, cred}, 32'd0);
      last_cred = '0;
    end else if (expq.size() > 0 && expq[0].due == cyc) begin
      chk("out_valid", {31'b0, out_valid}, 32'd1);
      chk("cred", {20'b0, cred}, {20'b0, expq[0].val});
      chk("cred_range", {31'b0, (cred < 12'd3329)}, 32'd1);
      last_cred = expq[0].val;
      void'(expq.pop_front());
    end else begin
      chk("idle_valid", {31'b0, out_valid}, 32'd0);
      chk("cred_hold", {20'b0, cred}, {20'b0, last_cred});
    end
  endtask

  logic [23:0] dir_vals [6] = '{24'd0, 24'd3330, 24'd99999, 24'd65536, 24'd600000, 24'd16777215};
  logic [23:0] bnd_vals [4] = '{24'd3328, 24'd3329, 24'd255, 24'd256};

  initial begin
    // Reset with in_valid high: must be ignored.
    tick(1'b1, 24'd12345, 1'b1);
    tick(1'b1, 24'd54321, 1'b1);

    // Anchor a few absolute values independent of the model.
    tick(1'b1, 24'd3330, 1'b0);
    tick(1'b0, 24'd0, 1'b0);
    tick(1'b0, 24'd0, 1'b0);
    chk("abs_3330", {20'b0, cred}, 32'd169);
    tick(1'b1, 24'd16777215, 1'b0);
    tick(1'b0, 24'd0, 1'b0);
    tick(1'b0, 24'd0, 1'b0);
    chk("abs_max", {20'b0, cred}, 32'd87);
    tick(1'b1, 24'd3328, 1'b0);
    tick(1'b0, 24'd0, 1'b0);
    tick(1'b0, 24'd0, 1'b0);
    chk("abs_3328", {20'b0, cred}, 32'd3160);

    // Single inputs with idle gaps.
    foreach (dir_vals[i]) begin
      tick(1'b1, dir_vals[i], 1'b0);
      repeat (3) tick(1'b0, 24'hABCDEF, 1'b0);
    end
    foreach (bnd_vals[i]) begin
      tick(1'b1, bnd_vals[i], 1'b0);
      repeat (3) tick(1'b0, 24'd0, 1'b0);
    end

    // Streaming back-to-back.
    foreach (dir_vals[i]) tick(1'b1, dir_vals[i], 1'b0);
    foreach (bnd_vals[i]) tick(1'b1, bnd_vals[i], 1'b0);
    repeat (4) tick(1'b0, 24'd0, 1'b0);

    // Reset with two inputs in flight.
    tick(1'b1, 24'd99999, 1'b0);
    tick(1'b1, 24'd600000, 1'b0);
    tick(1'b1, 24'd777, 1'b1);
    repeat (4) tick(1'b0, 24'd0, 1'b0);
    tick(1'b1, 24'd65536, 1'b0);
    repeat (3) tick(1'b0, 24'd0, 1'b0);

    // Randomized stream with gaps and occasional extreme operands.
    for (int n = 0; n < 20000; n++) begin
      logic [23:0] x;
      logic        v;
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 15))
        0:       x = 24'hFFFFFF;
        1:       x = 24'd0;
        2:       x = 24'($urandom_range(0, 511));
        default: x = 24'($urandom());
      endcase
      tick(v, x, 1'b0);
    end
    repeat (4) tick(1'b0, 24'd0, 1'b0);
    chk("drained", expq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
